// File: rtl/tt_mul_pkg.sv
// Shared types and sizes for the multiplier/divider slice.
// Divider state encoding and width constants.
package tt_mul_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] a_next,
  output logic             q_bit
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] d_n;
  logic [WIDTH:0] t;
  logic [WIDTH:0] c;

  assign a_sh = {a, q_msb};
  assign d_n  = ~{1'b0, divisor};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    fa u_fa (
      .a  (a_sh[i]),
      .b  (d_n[i]),
      .ci (c[i]),
      .s  (t[i]),
      .co (c[i+1])
    );
  end

  // Sign bit only: its carry out is never needed.
  assign t[WIDTH] = a_sh[WIDTH] ^ d_n[WIDTH] ^ c[WIDTH];

  // A stays below the divisor, so a non-negative T fits in WIDTH bits.
  assign q_bit  = ~t[WIDTH];
  assign a_next = q_bit ? t[WIDTH-1:0] : a_sh[WIDTH-1:0];

endmodule

// File: rtl/fa.sv
// Full-adder cell.
// Shared by the multiplier and divider datapaths.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring unsigned divider.
// One quotient bit per clock, start/busy/done handshake.
module seq_divider_8bit
  import tt_mul_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  assign q_next = {q_r[WIDTH-2:0], q_bit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a       (a_r),
    .q_msb   (q_r[WIDTH-1]),
    .divisor (dvs_r),
    .a_next  (a_next),
    .q_bit   (q_bit)
  );

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_IDLE;
      a_r       <= '0;
      q_r       <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (start) begin
            state    <= DIV_RUN;
            dvs_r    <= divisor;
            a_r      <= '0;
            q_r      <= dividend;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            div_zero <= (divisor == '0);
          end
        end
        DIV_RUN: begin
          a_r <= a_next;
          q_r <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DIV_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= a_next;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit.
// Table vectors, handshake corner cases, random pairs vs / and %.
module tb_seq_divider_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  seq_divider_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model(input int a, input int b,
                                output int q, output int r,
                                output int dz);
    if (b == 0) begin
      q = 255; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  // Present operands with start for one accepting edge, then scramble them.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    dividend = 8'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_exp(input string name, input int a, input int b,
                         input int q, input int r, input int dz,
                         input bit timing);
    int lat;
    int bcnt;
    launch(a, b);
    wait_done(lat, bcnt);
    if (timing) begin
      check({name, "_lat"}, lat, 8);
      check({name, "_busy"}, bcnt, 8);
    end else if (lat != 8) begin
      check({name, "_lat"}, lat, 8);
    end
    check({name, "_q"}, quotient, q);
    check({name, "_r"}, remainder, r);
    check({name, "_dz"}, div_zero, dz);
  endtask

  initial begin
    int lat;
    int bcnt;
    int q;
    int r;
    int dz;
    int a;
    int b;
    int sel;
    bit hold;
    bit seen;

    tbl[0] = '{200,   7,  28,  4, 0};
    tbl[1] = '{255,   1, 255,  0, 0};
    tbl[2] = '{  5,   9,   0,  5, 0};
    tbl[3] = '{  0,   3,   0,  0, 0};
    tbl[4] = '{128, 128,   1,  0, 0};
    tbl[5] = '{ 77,   0, 255, 77, 1};
    tbl[6] = '{255, 255,   1,  0, 0};
    tbl[7] = '{  0,   0, 255,  0, 1};
    tbl[8] = '{  1, 255,   0,  1, 0};
    tbl[9] = '{255,   2, 127,  1, 0};

    #12;
    check("reset_outs", int'({busy, done, div_zero, quotient, remainder}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_exp($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].q, tbl[i].r, tbl[i].dz, 1'b1);
    end

    // start pulses during RUN must be ignored.
    launch(100, 10);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      start    = (lat == 2 || lat == 4);
      dividend = 8'd33;
      divisor  = 8'd4;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("ign_lat", lat, 8);
    check("ign_q", quotient, 10);
    check("ign_r", remainder, 0);

    // Result holds in DONE, then through the next RUN.
    run_exp("b2b_first", 9, 2, 4, 1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", int'({done, quotient, remainder}),
          int'({1'b1, 8'd4, 8'd1}));
    launch(250, 16);
    check("done_clr", done, 0);
    hold = 1'b1;
    lat  = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && (quotient != 8'd4 || remainder != 8'd1)) hold = 1'b0;
    end
    check("b2b_hold", hold, 1);
    check("b2b_lat", lat, 8);
    check("b2b_q", quotient, 15);
    check("b2b_r", remainder, 10);

    // Asynchronous reset in the middle of a division.
    launch(200, 7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", int'({busy, done, div_zero, quotient, remainder}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("rst_nodone", seen, 0);
    run_exp("rst_fresh", 200, 7, 28, 4, 0, 1'b1);

    // Random pairs against plain integer division.
    for (int i = 0; i < 2000; i++) begin
      a   = $urandom_range(0, 255);
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      else if (sel == 1) b = $urandom_range(1, 3);
      else b = $urandom_range(0, 255);
      model(a, b, q, r, dz);
      run_exp($sformatf("rnd%0d_%0d/%0d", i, a, b), a, b, q, r, dz, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
